// File: rtl/pi_mem_bridge.sv
// Bridges SPI-domain access strobes onto a req/ack memory port in the clk domain.
// Each access is bounded by a timeout; protocol faults are kept in sticky flags.
module pi_mem_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 12,
  parameter int AW          = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pi_act,
  input  logic          pi_oe,
  input  logic          pi_we,
  input  logic [AW-1:0] pi_addr,
  input  logic [7:0]    pi_dato,
  output logic [7:0]    pi_dati,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          err,
  output logic          ovf,
  input  logic          flag_clr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                 hist_reg;
  logic                 sync_out, act_rise;
  logic [7:0]           tmo_ctr_reg, tmo_ctr_next;
  logic                 mem_req_reg, mem_req_next;
  logic                 mem_we_reg, mem_we_next;
  logic [AW-1:0]        mem_addr_reg, mem_addr_next;
  logic [7:0]           mem_wdata_reg, mem_wdata_next;
  logic [7:0]           pi_dati_reg, pi_dati_next;
  logic                 err_reg, err_next;
  logic                 ovf_reg, ovf_next;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign act_rise = sync_out & ~hist_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pi_act};
      hist_reg <= sync_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      tmo_ctr_reg   <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      pi_dati_reg   <= 8'hFF;
      err_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tmo_ctr_reg   <= tmo_ctr_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      pi_dati_reg   <= pi_dati_next;
      err_reg       <= err_next;
      ovf_reg       <= ovf_next;
    end
  end

  // Command lines are only looked at in the act_rise cycle; they are multicycle paths.
  always_comb begin
    state_next     = state_reg;
    tmo_ctr_next   = tmo_ctr_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    pi_dati_next   = pi_dati_reg;
    err_next       = err_reg;
    ovf_next       = ovf_reg;

    if (flag_clr) begin
      err_next = 1'b0;
      ovf_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (act_rise) begin
          if (pi_oe ^ pi_we) begin
            mem_addr_next  = pi_addr;
            mem_wdata_next = pi_dato;
            mem_we_next    = pi_we;
            mem_req_next   = 1'b1;
            tmo_ctr_next   = '0;
            state_next     = REQ;
          end else begin
            state_next = WAIT_LOW;
          end
        end
      end
      REQ: begin
        tmo_ctr_next = tmo_ctr_reg + 8'd1;
        // An ack landing on the timeout cycle still completes the access.
        if (mem_ack) begin
          mem_req_next = 1'b0;
          if (!mem_we_reg) pi_dati_next = mem_rdata;
          state_next = WAIT_LOW;
        end else if (tmo_ctr_reg == TMO_LAST) begin
          mem_req_next = 1'b0;
          err_next     = 1'b1;
          if (!mem_we_reg) pi_dati_next = 8'hFF;
          state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!sync_out) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (act_rise && state_reg != IDLE) ovf_next = 1'b1;
  end

  assign pi_dati   = pi_dati_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = (state_reg != IDLE);
  assign err       = err_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pi_mem_bridge.sv
// Directed plus randomized bench for pi_mem_bridge; the bench plays the memory arbiter
// and predicts read-back data from a simple byte-memory model.
module tb_pi_mem_bridge;

  localparam int SS  = 2;
  localparam int TMO = 12;
  localparam int AW  = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          pi_act, pi_oe, pi_we;
  logic [AW-1:0] pi_addr;
  logic [7:0]    pi_dato, pi_dati;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          busy, err, ovf, flag_clr;

  int errors = 0;
  int checks = 0;

  logic [7:0] arb_mem [logic [AW-1:0]];

  always #5 clk = ~clk;

  pi_mem_bridge #(.SYNC_STAGES(SS), .TIMEOUT(TMO), .AW(AW)) dut (
    .clk(clk), .rst(rst), .pi_act(pi_act), .pi_oe(pi_oe), .pi_we(pi_we),
    .pi_addr(pi_addr), .pi_dato(pi_dato), .pi_dati(pi_dati),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err(err), .ovf(ovf), .flag_clr(flag_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One full access: raise act, observe request, answer as the arbiter, lower act, wait idle.
  // ack_lat = req cycle in which ack is given (0 = never); dip_at/clr_at = req cycle of an
  // act low-pulse / flag_clr pulse (0 = none).
  task automatic access(input string name, input logic oe, input logic we,
                        input logic [AW-1:0] addr, input logic [7:0] d,
                        input int ack_lat, input int dip_at, input int clr_at,
                        output int lat, output int req_cycles, output int extra_req,
                        output logic busy_seen);
    lat = 0; req_cycles = 0; extra_req = 0; busy_seen = 1'b0;
    @(negedge clk);
    pi_oe = oe; pi_we = we; pi_addr = addr; pi_dato = d; pi_act = 1'b1;
    for (int i = 1; i <= SS + 4 && lat == 0; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (mem_req) lat = i;
    end
    if (oe ^ we) begin
      chk({name, "/req_latency"}, lat, SS + 1);
      chk({name, "/mem_we"}, mem_we, we);
      chk({name, "/mem_addr"}, mem_addr, addr);
      chk({name, "/mem_wdata"}, mem_wdata, d);
    end
    while (mem_req === 1'b1 && req_cycles < 300) begin
      req_cycles++;
      if (req_cycles == dip_at) pi_act = 1'b0;
      if (dip_at != 0 && req_cycles == dip_at + 1) pi_act = 1'b1;
      if (req_cycles == clr_at) flag_clr = 1'b1;
      if (req_cycles == ack_lat) begin
        mem_ack = 1'b1;
        if (mem_we) arb_mem[mem_addr] = mem_wdata;
        mem_rdata = arb_mem.exists(mem_addr) ? arb_mem[mem_addr] : 8'h00;
      end
      @(negedge clk);
      mem_ack = 1'b0; flag_clr = 1'b0; mem_rdata = 8'($urandom);
    end
    pi_act = 1'b1;
    @(negedge clk);
    pi_act = 1'b0;
    for (int i = 0; i < 12 && busy; i++) begin
      @(negedge clk);
      if (mem_req) extra_req++;
    end
    chk({name, "/busy_low"}, busy, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int lat, cyc, extra;
  logic bsy;

  initial begin
    logic [AW-1:0] pool [4];
    logic [7:0]    model_mem [4];
    logic [7:0]    exp_dati;
    logic          exp_err;

    rst = 1'b1; pi_act = 1'b0; pi_oe = 1'b0; pi_we = 1'b0; pi_addr = '0; pi_dato = '0;
    mem_ack = 1'b0; mem_rdata = '0; flag_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/mem_req", mem_req, 1'b0);
    chk("rst/mem_we", mem_we, 1'b0);
    chk("rst/mem_addr", mem_addr, 0);
    chk("rst/mem_wdata", mem_wdata, 0);
    chk("rst/pi_dati", pi_dati, 8'hFF);
    chk("rst/err", err, 1'b0);
    chk("rst/ovf", ovf, 1'b0);
    chk("rst/busy", busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write, acked on the 3rd request cycle
    access("wr", 1'b0, 1'b1, 25'h0000123, 8'h5A, 3, 0, 0, lat, cyc, extra, bsy);
    chk("wr/req_cycles", cyc, 3);
    chk("wr/pi_dati", pi_dati, 8'hFF);
    chk("wr/err", err, 1'b0);
    chk("wr/stored", arb_mem[25'h0000123], 8'h5A);

    // Read, acked on the 2nd request cycle
    arb_mem[25'h0800010] = 8'hC3;
    access("rd", 1'b1, 1'b0, 25'h0800010, 8'h00, 2, 0, 0, lat, cyc, extra, bsy);
    chk("rd/req_cycles", cyc, 2);
    chk("rd/pi_dati", pi_dati, 8'hC3);

    // Timeout, then a second timeout coinciding with flag_clr
    access("tmo1", 1'b1, 1'b0, 25'h0000040, 8'h00, 0, 0, 0, lat, cyc, extra, bsy);
    chk("tmo1/req_cycles", cyc, TMO);
    chk("tmo1/pi_dati", pi_dati, 8'hFF);
    chk("tmo1/err", err, 1'b1);
    repeat (3) @(negedge clk);
    chk("tmo1/err_held", err, 1'b1);
    access("tmo2", 1'b1, 1'b0, 25'h0000041, 8'h00, 0, 0, TMO, lat, cyc, extra, bsy);
    chk("tmo2/err_set_wins", err, 1'b1);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("tmo2/err_cleared", err, 1'b0);

    // Illegal command (both set), then a legal access
    access("ill", 1'b1, 1'b1, 25'h0000077, 8'h11, 1, 0, 0, lat, cyc, extra, bsy);
    chk("ill/no_req", lat, 0);
    chk("ill/busy_pulse", bsy, 1'b1);
    chk("ill/ovf", ovf, 1'b0);
    access("post_ill", 1'b0, 1'b1, 25'h0000078, 8'h22, 4, 0, 0, lat, cyc, extra, bsy);
    chk("post_ill/req_cycles", cyc, 4);

    // Overflow: act dips low for one clk during REQ
    arb_mem[25'h1234567] = 8'h96;
    access("ovf", 1'b1, 1'b0, 25'h1234567, 8'h00, 10, 2, 0, lat, cyc, extra, bsy);
    chk("ovf/flag", ovf, 1'b1);
    chk("ovf/req_cycles", cyc, 10);
    chk("ovf/extra_req", extra, 0);
    chk("ovf/pi_dati", pi_dati, 8'h96);

    // Reset in the 2nd request cycle, followed by a stray ack
    @(negedge clk);
    pi_oe = 1'b1; pi_we = 1'b0; pi_addr = 25'h0ABCDEF; pi_act = 1'b1;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    chk("rstreq/req_up", mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1; pi_act = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstreq/mem_req", mem_req, 1'b0);
    chk("rstreq/busy", busy, 1'b0);
    chk("rstreq/pi_dati", pi_dati, 8'hFF);
    chk("rstreq/err", err, 1'b0);
    chk("rstreq/ovf", ovf, 1'b0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rstreq/ack_ignored", pi_dati, 8'hFF);
    chk("rstreq/still_idle", busy, 1'b0);

    // Randomized accesses against a byte-memory model
    for (int k = 0; k < 4; k++) begin
      pool[k] = {23'($urandom), 2'(k)};
      model_mem[k] = 8'($urandom);
      arb_mem[pool[k]] = model_mem[k];
    end
    exp_dati = pi_dati;
    exp_err  = 1'b0;
    for (int n = 0; n < 24; n++) begin
      int k, cmd, ack_l;
      logic oe, we;
      logic [7:0] d;
      string nm;
      k = $urandom_range(0, 3);
      cmd = $urandom_range(0, 5);
      ack_l = $urandom_range(1, 14);
      d = 8'($urandom);
      oe = (cmd <= 1) || (cmd == 4);
      we = (cmd == 2) || (cmd == 3) || (cmd == 4);
      if ($urandom_range(0, 3) == 0) begin
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        exp_err = 1'b0;
      end
      nm = $sformatf("rnd%0d", n);
      access(nm, oe, we, pool[k], d, ack_l, 0, 0, lat, cyc, extra, bsy);
      if (oe ^ we) begin
        if (ack_l > TMO) begin
          exp_err = 1'b1;
          if (oe) exp_dati = 8'hFF;
        end else if (oe) begin
          exp_dati = model_mem[k];
        end else begin
          model_mem[k] = d;
        end
        chk({nm, "/req_cycles"}, cyc, (ack_l > TMO) ? TMO : ack_l);
      end else begin
        chk({nm, "/no_req"}, lat, 0);
      end
      chk({nm, "/pi_dati"}, pi_dati, exp_dati);
      chk({nm, "/err"}, err, exp_err);
      chk({nm, "/ovf"}, ovf, 1'b0);
      chk({nm, "/extra_req"}, extra, 0);
      $display("txn %0d: oe=%0b we=%0b addr=0x%0h ack_lat=%0d pi_dati=0x%0h err=%0b",
               n, oe, we, pool[k], ack_l, pi_dati, err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
